window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the 9-input sorter/median stage.
- Accepts one 8-bit pixel per cycle in raster order and buffers two previous image lines.
- Presents the 9 pixels of each complete 3x3 window on outputs a..i. The downstream stage consumes a..i combinationally.

Parameters:
- DATA_W, 8, pixel width; must be 8 to match the sorter stage.
- IMG_W, 640, pixels per line; must be >= 3.
- IMG_H, 480, lines per frame; must be >= 3.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_pixel accepted this cycle when high.
- in_sof  in  1  qualifies in_valid; the accepted pixel is position (row 0, col 0).
- in_pixel  in  DATA_W  input pixel.
- out_valid  out  1  a..i hold a complete window.
- a, b, c  out  DATA_W  window top row, left to right.
- d, e, f  out  DATA_W  window middle row, left to right.
- g, h, i  out  DATA_W  window bottom row, left to right.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0 and a..i=0.
  - col=0 and row=0.
  - Both line buffers cleared to 0.
- Counters:
  - col is 0..IMG_W-1 and row is 0..IMG_H-1, each $clog2-sized.
  - They advance only on an accepted pixel (in_valid=1).
  - col wraps IMG_W-1 to 0 and increments row.
  - row wraps IMG_H-1 to 0 at end of frame.
- SOF:
  - in_valid&&in_sof forces the accepted pixel to (0,0); next col=1 and row=0, regardless of the old count.
  - Mid-frame SOF restarts the frame; stale line-buffer data is harmless because no window is valid before row 2.
  - in_sof without in_valid is ignored.
- Line buffers:
  - Two shift registers, IMG_W deep.
  - LB1 output is the pixel at (r-1,c); LB2 output is the pixel at (r-2,c).
  - On an accepted pixel: LB1 shifts in in_pixel and LB2 shifts in LB1's output.
  - No shift when in_valid=0.
- Window registers:
  - On an accepted pixel, each window row shifts one column left: a<=b<=c, d<=e<=f, g<=h<=i.
  - The new right column is c<=LB2 out, f<=LB1 out, i<=in_pixel.
- Output timing and mapping:
  - Latency is 1 cycle: out_valid is registered and high in the cycle after an accepted pixel at (r,c) with r>=2 and c>=2.
  - The window is centred on (r-1,c-1), with i=(r,c) and a=(r-2,c-2).
- Idle and rate:
  - in_valid=0: window registers and counters hold; out_valid=0 the next cycle (a..i hold their last values).
  - Exactly (IMG_W-2)*(IMG_H-2) windows are produced per frame.
  - No backpressure; throughput is 1 window/cycle.
- Row transitions:
  - Windows straddling a line wrap (col 0,1) are never flagged valid.
  - A window at row 2, col 2 needs no special handling beyond the counters.

Optional Feature:
- Macro: WINDOW_3X3_LAST_EN.
- Defined:
  - Adds output out_last (1 bit, reset 0).
  - out_last is high together with out_valid only for the window produced by the pixel at (IMG_H-1, IMG_W-1), i.e. the final window of the frame.
  - It is cleared on any cycle where out_valid is 0.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
1. IMG_W=4, IMG_H=4, pixels 0..15 back-to-back with SOF on pixel 0.
   - out_valid high exactly 4 times, on the cycles after pixels 10, 11, 14, 15.
   - After pixel 10: a..i = 0,1,2,4,5,6,8,9,10.
   - After pixel 15: a..i = 5,6,7,9,10,11,13,14,15.
2. Same stream with in_valid low for 3 cycles between every pixel.
   - Identical 4 windows.
   - out_valid is a single-cycle pulse each time; a..i hold during gaps.
3. Two consecutive frames, second frame pixels 100..115.
   - Second frame's first window (after pixel 110) = 100,101,102,104,105,106,108,109,110.
   - Exactly 8 windows total across both frames.
4. Assert rst_n low for 1 cycle after pixel 9, then restart with SOF.
   - Immediately after reset: out_valid=0 and a..i=0.
   - The next valid window appears only after the 11th post-reset pixel.
5. Mid-frame SOF: send pixels 0..6, then SOF with pixels 20..35.
   - No window before pixel 30.
   - Window after pixel 30 = 20,21,22,24,25,26,28,29,30.
6. WINDOW_3X3_LAST_EN defined, scenario 1.
   - out_last high only with the window after pixel 15; low for the other 3.

Source files
------------

// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
//
// Streaming 3x3 neighbourhood generator feeding the 9-input sorter/median
// stage. Pixels arrive one per accepted cycle in raster order. Two IMG_W-deep
// line buffers hold the previous two image lines, and a 3x3 register window
// presents the neighbourhood on a..i one cycle after the pixel that completes
// it.
//
// Optional feature: define WINDOW_3X3_LAST_EN to add out_last, which flags the
// final window of the frame (the window produced by pixel (IMG_H-1, IMG_W-1)).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_pixel accepted this cycle
//   in_sof    in   with in_valid: accepted pixel is (row 0, col 0)
//   in_pixel  in   DATA_W pixel
//   out_valid out  a..i hold a complete window
//   out_last  out  (WINDOW_3X3_LAST_EN only) last window of the frame
//   a,b,c     out  window top row, left to right
//   d,e,f     out  window middle row, left to right
//   g,h,i     out  window bottom row, left to right (i = newest pixel)
// -----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
`ifdef WINDOW_3X3_LAST_EN
    output logic              out_last,
`endif
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h,
    output logic [DATA_W-1:0] i
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

    logic [COL_W-1:0]  col_q, col_d, pos_col;
    logic [ROW_W-1:0]  row_q, row_d, pos_row;
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb1_d [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];
    logic [DATA_W-1:0] lb2_d [IMG_W];
    // win_q[0..8] map to a..i
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic              out_valid_q, out_valid_d;
`ifdef WINDOW_3X3_LAST_EN
    logic              out_last_q, out_last_d;
`endif

    always_comb begin
        // SOF overrides whatever position the counters hold.
        pos_col     = in_sof ? '0 : col_q;
        pos_row     = in_sof ? '0 : row_q;
        col_d       = col_q;
        row_d       = row_q;
        lb1_d       = lb1_q;
        lb2_d       = lb2_q;
        win_d       = win_q;
        out_valid_d = 1'b0;
`ifdef WINDOW_3X3_LAST_EN
        out_last_d  = 1'b0;
`endif
        if (in_valid) begin
            if (pos_col == COL_MAX) begin
                col_d = '0;
                row_d = (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end

            // Oldest entry of each buffer is the same column one line back.
            lb1_d[0] = in_pixel;
            lb2_d[0] = lb1_q[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                lb1_d[k] = lb1_q[k-1];
                lb2_d[k] = lb2_q[k-1];
            end

            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_q[IMG_W-1];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_q[IMG_W-1];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pixel;

            // Columns 0 and 1 would straddle a line wrap, rows 0 and 1 lack
            // history, so only r>=2, c>=2 produce a real window.
            out_valid_d = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
`ifdef WINDOW_3X3_LAST_EN
            out_last_d  = (pos_row == ROW_MAX) && (pos_col == COL_MAX);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef WINDOW_3X3_LAST_EN
            out_last_q  <= 1'b0;
`endif
            for (int k = 0; k < IMG_W; k++) begin
                lb1_q[k] <= '0;
                lb2_q[k] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
`ifdef WINDOW_3X3_LAST_EN
            out_last_q  <= out_last_d;
`endif
            lb1_q       <= lb1_d;
            lb2_q       <= lb2_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
`ifdef WINDOW_3X3_LAST_EN
    assign out_last  = out_last_q;
`endif
    assign a = win_q[0];
    assign b = win_q[1];
    assign c = win_q[2];
    assign d = win_q[3];
    assign e = win_q[4];
    assign f = win_q[5];
    assign g = win_q[6];
    assign h = win_q[7];
    assign i = win_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_last;
    logic [7:0] a, b, c, d, e, f, g, h, i;

    window_3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
`ifdef WINDOW_3X3_LAST_EN
        .out_last (out_last),
`endif
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i)
    );

`ifndef WINDOW_3X3_LAST_EN
    assign out_last = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nwin  = 0;

    // Reference model: raw accepted-pixel history, current frame image and
    // raster position.
    logic [7:0] hist[$];
    logic [7:0] img [0:H-1][0:W-1];
    int         mr = 0, mc = 0;
    int         cur_r = 0, cur_c = 0;
    logic       exp_v = 1'b0;
    logic       exp_l = 1'b0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hk(input int k);
        if (k < hist.size()) return hist[hist.size()-1-k];
        return 8'd0;
    endfunction

    // Window from the line-buffer view: same column one and two lines back.
    function automatic logic [71:0] hist_window();
        return {hk(2*W+2), hk(2*W+1), hk(2*W), hk(W+2), hk(W+1), hk(W), hk(2), hk(1), hk(0)};
    endfunction

    // Window from the image view: rows r-2..r, cols c-2..c.
    function automatic logic [71:0] img_window();
        return {img[cur_r-2][cur_c-2], img[cur_r-2][cur_c-1], img[cur_r-2][cur_c],
                img[cur_r-1][cur_c-2], img[cur_r-1][cur_c-1], img[cur_r-1][cur_c],
                img[cur_r][cur_c-2],   img[cur_r][cur_c-1],   img[cur_r][cur_c]};
    endfunction

    function automatic logic [71:0] obs_window();
        return {a, b, c, d, e, f, g, h, i};
    endfunction

    task automatic model_reset();
        hist.delete();
        mr = 0; mc = 0;
        exp_v = 1'b0; exp_l = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [7:0] px);
        exp_v = 1'b0;
        exp_l = 1'b0;
        if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = px;
            hist.push_back(px);
            if (hist.size() > 2*W+3) void'(hist.pop_front());
            cur_r = mr; cur_c = mc;
            exp_v = (mr >= 2) && (mc >= 2);
            exp_l = (mr == H-1) && (mc == W-1);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
    endtask

    // One clock: drive, let the edge happen, then check 1 time unit later.
    task automatic cyc(input logic v, input logic s, input logic [7:0] px);
        in_valid = v; in_sof = s; in_pixel = px;
        @(posedge clk);
        model_step(v, s, px);
        #1;
        chk("out_valid", {71'd0, out_valid}, {71'd0, exp_v});
        chk("window_hist", obs_window(), hist_window());
        if (exp_v) begin
            chk("window_img", obs_window(), img_window());
            nwin++;
        end
`ifdef WINDOW_3X3_LAST_EN
        chk("out_last", {71'd0, out_last}, {71'd0, exp_l && exp_v});
`endif
    endtask

    // Window after pixel p of a W=4 frame whose pixels are base+0..base+15.
    function automatic logic [71:0] lin_window(input int base, input int p);
        int o;
        o = base + p - 10;
        return {8'(o), 8'(o+1), 8'(o+2), 8'(o+4), 8'(o+5), 8'(o+6), 8'(o+8), 8'(o+9), 8'(o+10)};
    endfunction

    task automatic frame(input int base, input int gap, input string tag);
        int w0;
        w0 = nwin;
        for (int p = 0; p < W*H; p++) begin
            cyc(1'b1, p == 0, 8'(base + p));
            if (p == 10 || p == 11 || p == 14 || p == 15)
                chk({tag, "_lin"}, obs_window(), lin_window(base, p));
            for (int q = 0; q < gap; q++) cyc(1'b0, 1'($urandom), 8'($urandom));
        end
        chk({tag, "_count"}, 72'(nwin - w0), 72'((W-2)*(H-2)));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {71'd0, out_valid}, 72'd0);
        chk("rst_window", obs_window(), 72'd0);
        chk("rst_last", {71'd0, out_last}, 72'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int w0;
        rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'd0;
        @(posedge clk);
        do_reset();

        // Back-to-back frame 0..15
        frame(0, 0, "t1");
        // Same stream with 3 idle cycles between pixels
        frame(0, 3, "t2");
        // Two consecutive frames
        w0 = nwin;
        frame(0, 0, "t3a");
        frame(100, 0, "t3b");
        chk("t3_total", 72'(nwin - w0), 72'd8);

        // Reset after pixel 9, then restart
        for (int p = 0; p < 10; p++) cyc(1'b1, p == 0, 8'(p));
        do_reset();
        w0 = nwin;
        for (int p = 0; p < 11; p++) begin
            cyc(1'b1, p == 0, 8'(p));
            if (p < 10) chk("t4_early", 72'(nwin - w0), 72'd0);
        end
        chk("t4_first", {71'd0, out_valid}, 72'd1);
        chk("t4_win", obs_window(), lin_window(0, 10));
        for (int p = 11; p < 16; p++) cyc(1'b1, 1'b0, 8'(p));

        // Mid-frame SOF
        for (int p = 0; p < 7; p++) cyc(1'b1, p == 0, 8'(p));
        frame(20, 0, "t5");

        // Random frames with random gaps and occasional mid-frame restarts
        for (int fr = 0; fr < 12; fr++) begin
            for (int p = 0; p < W*H; p++) begin
                cyc(1'b1, (p == 0) || ($urandom_range(0, 40) == 0), 8'($urandom));
                while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom), 8'($urandom));
            end
        end

        // Random back-to-back tail, then idle so the last window is observed
        for (int p = 0; p < 3*W*H; p++) cyc(1'b1, p == 0, 8'($urandom));
        cyc(1'b0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
